// File: rtl/blake2_ctrl_pkg.sv
// Types and constants shared by the Blake2 block-packing controller and its digest readout path.
package blake2_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } rd_state_t;

    localparam int DEF_BUS_WIDTH    = 32;
    localparam int DEF_DIGEST_WIDTH = 512;
    localparam int DEF_BLOCK_WIDTH  = 1024;

    // Number of bus words needed to carry len_bytes bytes (rounded up).
    function automatic int words_for(input int len_bytes, input int bytes_per_word);
        return (len_bytes + bytes_per_word - 1) / bytes_per_word;
    endfunction

endpackage

// File: rtl/digest_timeout_wdt.sv
// Watchdog for the digest wait: counts enabled cycles and flags expiry on the TIMEOUT_CYCLES-th.
// Expire is combinational from the count; clear has priority over counting.
module digest_timeout_wdt #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    assign expire = enable && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable && !expire) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/digest_reader.sv
// Latches the Blake2 digest on a fresh digest_valid rise after final_in and streams it as BUS_WIDTH words.
// Latency: first word one cycle after the captured rise; then one word per cycle.
// Backpressure: dout/keep/last hold while dout_ready is low. Watchdog under DIGEST_READER_TIMEOUT_EN.
module digest_reader
    import blake2_ctrl_pkg::*;
#(
    parameter int BUS_WIDTH      = DEF_BUS_WIDTH,
    parameter int DIGEST_WIDTH   = DEF_DIGEST_WIDTH,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              final_in,
    input  logic [$clog2(DIGEST_WIDTH/8):0]   digest_len,
    input  logic                              digest_valid,
    input  logic [DIGEST_WIDTH-1:0]           digest,
    output logic [BUS_WIDTH-1:0]              dout,
    output logic                              dout_valid,
    input  logic                              dout_ready,
    output logic                              dout_last,
    output logic [BUS_WIDTH/8-1:0]            dout_keep,
    output logic                              busy,
    output logic                              overrun,
    output logic                              timeout
);

    localparam int DB  = DIGEST_WIDTH / 8;
    localparam int BPW = BUS_WIDTH / 8;
    localparam int NW  = DIGEST_WIDTH / BUS_WIDTH;
    localparam int LW  = $clog2(DB) + 1;
    localparam int CW  = $clog2(NW) + 1;

    rd_state_t               state;
    logic [LW-1:0]           len_q;
    logic [CW-1:0]           wcnt;
    logic [CW-1:0]           nwords_q;
    logic [DIGEST_WIDTH-1:0] dig_q;
    logic                    dv_q;

    logic                    dv_rise;
    logic                    xfer;
    logic                    wdt_expire;
    logic [LW-1:0]           len_clamped;
    logic [CW-1:0]           nw_calc;

    logic [DIGEST_WIDTH-1:0] src_dig;
    logic [CW-1:0]           src_idx;
    logic [CW-1:0]           src_nw;
    logic [BUS_WIDTH-1:0]    nxt_dout;
    logic [BPW-1:0]          nxt_keep;
    logic                    nxt_last;

    assign dv_rise     = digest_valid && !dv_q;
    assign xfer        = dout_valid && dout_ready;
    assign len_clamped = (digest_len == '0 || int'(digest_len) > DB) ? LW'(DB) : digest_len;
    assign nw_calc     = CW'(words_for(int'(len_q), BPW));

    // Next word to present: word 0 straight from the engine on capture, else the following shadow word.
    always_comb begin
        src_dig = dig_q;
        src_idx = wcnt + CW'(1);
        src_nw  = nwords_q;
        if (state == WAIT) begin
            src_dig = digest;
            src_idx = '0;
            src_nw  = nw_calc;
        end
        nxt_dout = '0;
        nxt_keep = '0;
        for (int b = 0; b < BPW; b++) begin
            if (int'(src_idx) * BPW + b < int'(len_q)) begin
                nxt_keep[b]          = 1'b1;
                nxt_dout[b*8 +: 8]   = src_dig[(int'(src_idx) * BPW + b) * 8 +: 8];
            end
        end
        nxt_last = (src_idx == src_nw - CW'(1));
    end

`ifdef DIGEST_READER_TIMEOUT_EN
    digest_timeout_wdt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdt (
        .clk    (clk),
        .reset  (reset),
        .clear  (state != WAIT),
        .enable (state == WAIT),
        .expire (wdt_expire)
    );
`else
    // No watchdog: WAIT is left only on a digest rise or reset.
    assign wdt_expire = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            len_q      <= '0;
            wcnt       <= '0;
            nwords_q   <= '0;
            dig_q      <= '0;
            dv_q       <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            dout_keep  <= '0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            dv_q    <= digest_valid;
            overrun <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (final_in) begin
                        state <= WAIT;
                        len_q <= len_clamped;
                        wcnt  <= '0;
                        busy  <= 1'b1;
                    end
                end
                WAIT: begin
                    overrun <= final_in;
                    if (dv_rise) begin
                        state      <= SEND;
                        dig_q      <= digest;
                        nwords_q   <= nw_calc;
                        wcnt       <= '0;
                        dout       <= nxt_dout;
                        dout_keep  <= nxt_keep;
                        dout_last  <= nxt_last;
                        dout_valid <= 1'b1;
                    end else if (wdt_expire) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end
                end
                SEND: begin
                    overrun <= final_in && !(xfer && dout_last);
                    if (xfer) begin
                        wcnt <= wcnt + CW'(1);
                        if (dout_last) begin
                            dout       <= '0;
                            dout_keep  <= '0;
                            dout_last  <= 1'b0;
                            dout_valid <= 1'b0;
                            // A final_in coinciding with the last handshake starts the next readout.
                            if (final_in) begin
                                state <= WAIT;
                                len_q <= len_clamped;
                                wcnt  <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            dout      <= nxt_dout;
                            dout_keep <= nxt_keep;
                            dout_last <= nxt_last;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digest_reader.sv
// Scoreboard bench for digest_reader: byte-level reference model feeds an expected-word queue, a monitor checks handshakes.
module tb_digest_reader;

    localparam int BW  = 32;
    localparam int DW  = 512;
    localparam int DB  = DW / 8;
    localparam int BPW = BW / 8;
    localparam int TO  = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          final_in;
    logic [6:0]    digest_len;
    logic          digest_valid;
    logic [DW-1:0] digest;
    logic [BW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_last;
    logic [3:0]    dout_keep;
    logic          busy;
    logic          overrun;
    logic          timeout;

    digest_reader #(
        .BUS_WIDTH      (BW),
        .DIGEST_WIDTH   (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .final_in     (final_in),
        .digest_len   (digest_len),
        .digest_valid (digest_valid),
        .digest       (digest),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .dout_last    (dout_last),
        .dout_keep    (dout_keep),
        .busy         (busy),
        .overrun      (overrun),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] dat;
        logic [3:0]  keep;
        logic        last;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         rx_count = 0;
    int         ready_mode = 0;
    int         model_len = 0;
    logic [7:0] cur_bytes [DB];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: the digest is a byte string; word w carries bytes 4w..4w+3, little-endian, truncated at model_len.
    function automatic void model_push();
        int   nw;
        exp_t e;
        nw = (model_len + BPW - 1) / BPW;
        for (int w = 0; w < nw; w++) begin
            e = '0;
            for (int b = 0; b < BPW; b++) begin
                if (w * BPW + b < model_len) begin
                    e.dat[8*b +: 8] = cur_bytes[w * BPW + b];
                    e.keep[b]       = 1'b1;
                end
            end
            e.last = (w == nw - 1);
            exp_q.push_back(e);
        end
    endfunction

    task automatic fill_bytes(input bit incrementing);
        for (int i = 0; i < DB; i++) begin
            cur_bytes[i] = incrementing ? 8'(i) : 8'($urandom_range(0, 255));
        end
        for (int i = 0; i < DB; i++) begin
            digest[8*i +: 8] = cur_bytes[i];
        end
    endtask

    task automatic start(input int len);
        final_in   = 1'b1;
        digest_len = 7'(len);
        step();
        final_in   = 1'b0;
        model_len  = (len == 0 || len > DB) ? DB : len;
        check("busy_after_final", 64'(busy), 64'd1);
    endtask

    task automatic deliver();
        digest_valid = 1'b1;
        model_push();
        step();
        digest_valid = 1'b0;
        check("capture_latency", 64'(dout_valid), 64'd1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || dout_valid) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d_words_pending required=0", exp_q.size());
        end
        check("busy_after_done", 64'(busy), 64'd0);
    endtask

    // Monitor: pops one expectation per handshake and checks stall stability.
    logic [31:0] h_dout;
    logic [3:0]  h_keep;
    logic        h_last;
    logic        h_stall = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            h_stall = 1'b0;
        end else begin
            if (h_stall) begin
                check("stall_valid_hold", 64'(dout_valid), 64'd1);
                check("stall_dout_hold", 64'(dout), 64'(h_dout));
                check("stall_keep_hold", 64'(dout_keep), 64'(h_keep));
                check("stall_last_hold", 64'(dout_last), 64'(h_last));
            end
            if (dout_valid && dout_ready) begin
                rx_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=%0h required=none", dout);
                end else begin
                    e = exp_q.pop_front();
                    check("word_dout", 64'(dout), 64'(e.dat));
                    check("word_keep", 64'(dout_keep), 64'(e.keep));
                    check("word_last", 64'(dout_last), 64'(e.last));
                end
            end
            h_stall = dout_valid && !dout_ready;
            h_dout  = dout;
            h_keep  = dout_keep;
            h_last  = dout_last;
        end
    end

    initial begin
        int ph = 0;
        dout_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: dout_ready = 1'b1;
                1: begin
                    ph = (ph + 1) % 4;
                    dout_ready = (ph == 0 || ph == 3);
                end
                default: dout_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        int n;
        int first;
        int pulses;
        reset        = 1'b1;
        final_in     = 1'b0;
        digest_len   = '0;
        digest_valid = 1'b0;
        digest       = '0;
        repeat (3) step();
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_valid", 64'(dout_valid), 64'd0);
        check("rst_last", 64'(dout_last), 64'd0);
        check("rst_keep", 64'(dout_keep), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        reset = 1'b0;
        step();

        // Full-length readout, digest valid 10 cycles after final.
        fill_bytes(1'b1);
        rx_count = 0;
        start(64);
        repeat (9) step();
        deliver();
        drain(200);
        check("full_word_count", 64'(rx_count), 64'd16);

        // Partial last word.
        rx_count = 0;
        start(30);
        repeat (3) step();
        deliver();
        drain(200);
        check("partial_word_count", 64'(rx_count), 64'd8);

        // Length clamping: 0 and above the digest size both mean the full digest.
        start(0);
        deliver();
        drain(200);
        fill_bytes(1'b0);
        start(100);
        deliver();
        drain(200);

        // Stall pattern 1,0,0,1.
        fill_bytes(1'b1);
        ready_mode = 1;
        rx_count = 0;
        start(64);
        deliver();
        drain(400);
        check("stall_handshakes", 64'(rx_count), 64'd16);

        // Randomized lengths, digests and readiness.
        for (int t = 0; t < 12; t++) begin
            ready_mode = $urandom_range(0, 2);
            fill_bytes(1'b0);
            start($urandom_range(0, 80));
            repeat ($urandom_range(0, 5)) step();
            deliver();
            drain(400);
        end
        ready_mode = 0;

        // Stale digest_valid level, then overrun in WAIT.
        fill_bytes(1'b0);
        digest_valid = 1'b1;
        repeat (2) step();
        start(20);
        for (int i = 0; i < 4; i++) begin
            step();
            check("stale_no_capture", 64'(dout_valid), 64'd0);
        end
        final_in   = 1'b1;
        digest_len = 7'd8;
        step();
        final_in = 1'b0;
        check("overrun_pulse", 64'(overrun), 64'd1);
        step();
        check("overrun_one_cycle", 64'(overrun), 64'd0);
        check("overrun_busy", 64'(busy), 64'd1);
        check("overrun_still_wait", 64'(dout_valid), 64'd0);
        digest_valid = 1'b0;
        step();
        deliver();
        drain(200);

        // Back-to-back: final_in in the last-handshake cycle.
        fill_bytes(1'b0);
        start(16);
        deliver();
        n = 0;
        while (!(dout_valid && dout_last) && n < 50) begin
            step();
            n++;
        end
        check("b2b_reached_last", 64'(n < 50), 64'd1);
        final_in   = 1'b1;
        digest_len = 7'd12;
        step();
        final_in  = 1'b0;
        model_len = 12;
        check("b2b_busy", 64'(busy), 64'd1);
        check("b2b_no_overrun", 64'(overrun), 64'd0);
        check("b2b_valid_low", 64'(dout_valid), 64'd0);
        fill_bytes(1'b0);
        repeat (2) step();
        check("b2b_waiting", 64'(dout_valid), 64'd0);
        deliver();
        drain(200);

        // Reset while word 5 is presented.
        fill_bytes(1'b1);
        rx_count = 0;
        start(64);
        deliver();
        n = 0;
        while (rx_count < 4 && n < 50) begin
            step();
            n++;
        end
        check("rst_mid_reached_word5", 64'(rx_count), 64'd4);
        reset = 1'b1;
        exp_q.delete();
        step();
        check("rst_mid_valid", 64'(dout_valid), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        step();

        // Watchdog behaviour with no digest_valid.
        start(40);
        first  = -1;
        pulses = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (timeout) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
`ifdef DIGEST_READER_TIMEOUT_EN
        check("timeout_cycle", 64'(first), 64'd16);
        check("timeout_pulses", 64'(pulses), 64'd1);
        check("timeout_idle", 64'(busy), 64'd0);
`else
        check("no_timeout_pulses", 64'(pulses), 64'd0);
        check("no_timeout_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
`endif

        // Recovery after the aborted readout.
        fill_bytes(1'b0);
        start(8);
        deliver();
        drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
